// File: rtl/uart_boot_loader.sv
// UART boot loader: receives a little-endian word count followed by that many
// little-endian 32-bit words and writes them into instruction memory. The CPU
// is held in reset until the whole image has landed.
module uart_boot_loader #(
    parameter int ADDR_W      = 10,
    parameter int MAX_WORDS   = 1024,
    parameter int TIMEOUT_CYC = 2000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              restart,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_rst_n,
    output logic              boot_done,
    output logic              boot_err
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {LEN, LOAD, WRITE, DONE, ERROR} state_t;

    state_t          state, state_nx;
    logic [1:0]      rst_sync;
    logic            run;
    logic [31:0]     cnt;
    logic [31:0]     wreg;
    logic [ADDR_W:0] widx;        // one extra bit so index can equal MAX_WORDS
    logic [ADDR_W:0] widx_inc;
    logic [1:0]      bcnt;
    logic [TW-1:0]   tcnt;
    logic [31:0]     n_full;
    logic            tcount_en;
    logic            tmo;

    assign run       = rst_sync[1];
    assign widx_inc  = widx + (ADDR_W+1)'(1);
    assign n_full    = {rx_data, cnt[23:0]};
    assign mem_addr  = widx[ADDR_W-1:0];
    assign mem_wdata = wreg;

    // Idle counter only runs once a transfer is under way; a byte always
    // clears it, so a byte arriving on the expiry cycle wins.
    assign tcount_en = !rx_valid &&
                       ((state == LEN && bcnt != 2'd0) || state == LOAD || state == WRITE);
    assign tmo       = tcount_en && (tcnt == TW'(TIMEOUT_CYC - 1));

    // Reset release synchroniser; FSM stays frozen until two edges have passed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= LEN;
        else        state <= state_nx;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            LEN: begin
                if (rx_valid && bcnt == 2'd3) begin
                    if (n_full == 32'd0)                state_nx = DONE;
                    else if (n_full > 32'(MAX_WORDS))   state_nx = ERROR;
                    else                                state_nx = LOAD;
                end else if (tmo) begin
                    state_nx = ERROR;
                end
            end
            LOAD: begin
                if (rx_valid && bcnt == 2'd3) state_nx = WRITE;
                else if (tmo)                 state_nx = ERROR;
            end
            WRITE: begin
                if ({{(31-ADDR_W){1'b0}}, widx_inc} == cnt) state_nx = DONE;
                else if (tmo)                               state_nx = ERROR;
                else                                        state_nx = LOAD;
            end
            DONE, ERROR: begin
                if (restart) state_nx = LEN;
            end
            default: state_nx = LEN;
        endcase
        if (!run) state_nx = state;
    end

    // Datapath: count/word assembly, word index and idle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            wreg <= '0;
            widx <= '0;
            bcnt <= '0;
            tcnt <= '0;
        end else if (run) begin
            tcnt <= tcount_en ? tcnt + TW'(1) : '0;
            case (state)
                LEN: begin
                    if (rx_valid) begin
                        cnt[{bcnt, 3'b000} +: 8] <= rx_data;
                        bcnt <= bcnt + 2'd1;
                    end
                end
                LOAD, WRITE: begin
                    // The word being written was latched before WRITE, so a
                    // byte landing here only starts the next word.
                    if (rx_valid) begin
                        wreg[{bcnt, 3'b000} +: 8] <= rx_data;
                        bcnt <= bcnt + 2'd1;
                    end
                    if (state == WRITE) widx <= widx_inc;
                end
                DONE, ERROR: begin
                    if (restart) begin
                        cnt  <= '0;
                        widx <= '0;
                        bcnt <= '0;
                        tcnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered status outputs decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we    <= 1'b0;
            cpu_rst_n <= 1'b0;
            boot_done <= 1'b0;
            boot_err  <= 1'b0;
        end else begin
            mem_we    <= (state_nx == WRITE);
            cpu_rst_n <= (state_nx == DONE);
            boot_done <= (state_nx == DONE);
            boot_err  <= (state_nx == ERROR);
        end
    end

endmodule
